// File: rtl/reg_file_rd_pkg.sv
// reg_file_rd_pkg -- shared constants and types for the register file with
// a handshaked, registered two-port read path.
//   DEFAULT_DW : default register / data bus width
//   DEFAULT_AW : default address width (2**AW registers)
//   state_t    : read-controller FSM encoding (IDLE=0, RESP=1)
package reg_file_rd_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage : reg_file_rd_pkg

// File: rtl/reg_file_rd_reg_en.sv
// reg_en -- W-bit register with load enable and synchronous active-high reset.
// Used both for register-file storage and for the read-data output registers.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high, clears q to zero
//   en  : load enable; q takes d on the rising edge when set
//   d   : next value
//   q   : registered value
module reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : reg_en

// File: rtl/reg_file_rd.sv
// reg_file_rd -- 2**AW x DW register file, one write port and one handshaked
// dual-address read port with one-cycle latency and write-to-read bypass.
//   clk, rst          : clock; synchronous active-high reset
//   we, waddr, wdata  : write port; writes to address 0 are dropped
//   req_valid/ready   : read request handshake; raddr_a/raddr_b sampled on accept
//   rsp_valid/ready   : read response handshake; rdata_a/rdata_b held while stalled
module reg_file_rd
  import reg_file_rd_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam int NREGS = 2 ** AW;

  state_t        state;
  logic          accept;
  logic          wr_live;
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] next_a;
  logic [DW-1:0] next_b;

  // Register 0 is hardwired; it has no storage at all.
  assign regs[0] = '0;

  // NOTE: the storage array is reset on purpose: a reset must leave every
  // register reading zero, so each entry is a resettable flop, not a RAM.
  for (genvar i = 1; i < NREGS; i++) begin : g_store
    reg_en #(.W(DW)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we && (waddr == AW'(i))),
      .d   (wdata),
      .q   (regs[i])
    );
  end

  // A new request may enter whenever the output slot is empty or being drained.
  assign req_ready = (state == IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // A same-cycle write to the addressed register is forwarded so the response
  // reflects the value the register holds after this edge.
  assign wr_live = we && (waddr != '0);
  assign next_a  = (wr_live && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign next_b  = (wr_live && (waddr == raddr_b)) ? wdata : regs[raddr_b];

  reg_en #(.W(DW)) u_rdata_a (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (next_a),
    .q   (rdata_a)
  );

  reg_en #(.W(DW)) u_rdata_b (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (next_b),
    .q   (rdata_b)
  );

  // In RESP an accept implies rsp_ready, so the slot is refilled as it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= RESP;
        RESP:    if (rsp_ready && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule : reg_file_rd

// File: tb/tb_reg_file_rd.sv
// tb_reg_file_rd -- table-driven directed checks for reg_file_rd plus
// hand-written sequences for stall and reset-while-pending behaviour.
module tb_reg_file_rd;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rv;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          rr;
    logic          e_valid;
    logic          e_ready;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_rd #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic er,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(ev));
    check({tag, " req_ready"}, 32'(req_ready), 32'(er));
    check({tag, " rdata_a"},   32'(rdata_a),   32'(ea));
    check({tag, " rdata_b"},   32'(rdata_b),   32'(eb));
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic rr);
    we = w; waddr = wa; wdata = wd;
    req_valid = rv; raddr_a = ra; raddr_b = rb; rsp_ready = rr;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic w, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic rv, logic [AW-1:0] ra, logic [AW-1:0] rb, logic rr,
                              logic ev, logic er, logic [DW-1:0] ea, logic [DW-1:0] eb);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.rv = rv; v.ra = ra; v.rb = rb; v.rr = rr;
    v.e_valid = ev; v.e_ready = er; v.e_a = ea; v.e_b = eb;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    // Expected values describe outputs just after the edge that applies the vector.
    vecs[0]  = mk(1, 3, 8'h5A, 0, 0, 0, 1,  0, 1, 8'h00, 8'h00); // write 3=5A
    vecs[1]  = mk(0, 0, 8'h00, 1, 3, 0, 1,  1, 1, 8'h5A, 8'h00); // read 3,0
    vecs[2]  = mk(1, 0, 8'hFF, 1, 0, 3, 1,  1, 1, 8'h00, 8'h5A); // write to 0 ignored
    vecs[3]  = mk(1, 5, 8'h11, 0, 0, 0, 1,  0, 1, 8'h00, 8'h5A); // drain, write 5=11
    vecs[4]  = mk(1, 5, 8'h22, 1, 5, 5, 1,  1, 1, 8'h22, 8'h22); // bypass both ports
    vecs[5]  = mk(0, 0, 8'h00, 0, 0, 0, 1,  0, 1, 8'h22, 8'h22); // drain, data held
    vecs[6]  = mk(1, 1, 8'h01, 0, 0, 0, 1,  0, 1, 8'h22, 8'h22);
    vecs[7]  = mk(1, 2, 8'h02, 0, 0, 0, 1,  0, 1, 8'h22, 8'h22);
    vecs[8]  = mk(0, 0, 8'h00, 1, 1, 2, 1,  1, 1, 8'h01, 8'h02); // back-to-back x3
    vecs[9]  = mk(0, 0, 8'h00, 1, 2, 3, 1,  1, 1, 8'h02, 8'h5A);
    vecs[10] = mk(0, 0, 8'h00, 1, 3, 1, 1,  1, 1, 8'h5A, 8'h01);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 0, 1,  0, 1, 8'h5A, 8'h01);
    vecs[12] = mk(1, 6, 8'h66, 1, 1, 6, 1,  1, 1, 8'h01, 8'h66); // bypass port b only
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 0, 1,  0, 1, 8'h01, 8'h66);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    rst = 1'b0;
    check_out("reset", 0, 1, 8'h00, 8'h00);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rv,
            vecs[i].ra, vecs[i].rb, vecs[i].rr);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_a, vecs[i].e_b);
    end

    // Stall: response held for 4 cycles while its register is rewritten.
    drive(1, 4, 8'h44, 0, 0, 0, 1);
    step();
    drive(0, 0, 8'h00, 1, 4, 5, 0);
    step();
    check_out("stall_load", 1, 0, 8'h44, 8'h22);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 8'h77, 1, 5, 5, 0);
      step();
      check_out($sformatf("stall%0d", i), 1, 0, 8'h44, 8'h22);
    end
    drive(0, 0, 8'h00, 0, 0, 0, 1);
    #1;
    check("release req_ready", 32'(req_ready), 32'd1);
    step();
    check_out("release", 0, 1, 8'h44, 8'h22);
    drive(0, 0, 8'h00, 1, 4, 0, 1);
    step();
    check_out("reread4", 1, 1, 8'h77, 8'h00);

    // Reset with a response pending plus a colliding write and request.
    rst = 1'b1;
    drive(1, 7, 8'hEE, 1, 7, 7, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    #1;
    check_out("rst_pending", 0, 1, 8'h00, 8'h00);
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 8'h00, 1, AW'(i), AW'(i), 1);
      step();
      check_out($sformatf("cleared%0d", i), 1, 1, 8'h00, 8'h00);
    end
    drive(0, 0, 8'h00, 0, 0, 0, 1);
    step();
    check("final idle", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_rd

// File: doc/reg_file_rd.md
REG_FILE_RD -- requirements
Module: reg_file_rd

Interface
REQ-001 Parameter DW, default 8, data width of each register and read/write data bus.
REQ-002 Parameter AW, default 3, address width; register count is 2**AW.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  write enable for the write port.
REQ-006 waddr  input  AW  write address.
REQ-007 wdata  input  DW  write data.
REQ-008 req_valid  input  1  read request valid.
REQ-009 req_ready  output  1  read request can be accepted this cycle.
REQ-010 raddr_a  input  AW  read address A, sampled on request acceptance.
REQ-011 raddr_b  input  AW  read address B, sampled on request acceptance.
REQ-012 rsp_valid  output  1  read response valid.
REQ-013 rsp_ready  input  1  consumer accepts response this cycle.
REQ-014 rdata_a  output  DW  registered data for raddr_a.
REQ-015 rdata_b  output  DW  registered data for raddr_b.

Function
REQ-016 Storage SHALL be 2**AW registers of DW bits; register 0 SHALL read as 0 at all times.
REQ-017 On a rising edge with we=1 and waddr!=0, register[waddr] SHALL take wdata; writes to address 0 SHALL be ignored.
REQ-018 Controller SHALL be a two-state FSM: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-019 req_ready SHALL be 1 in IDLE and equal to rsp_ready in RESP (combinational, no dependence on req_valid).
REQ-020 Request accepted on an edge where req_valid=1 and req_ready=1; rdata_a/rdata_b SHALL be loaded on that edge, rsp_valid=1 from the next cycle (latency 1).
REQ-021 Transitions: IDLE->RESP on accept; RESP->IDLE on rsp_ready=1 with no accept; RESP->RESP on rsp_ready=1 with accept (back-to-back, one response per cycle).
REQ-022 While rsp_valid=1 and rsp_ready=0, rdata_a, rdata_b and rsp_valid SHALL hold stable regardless of writes or new requests.
REQ-023 Write-read bypass: if accept coincides with we=1, waddr!=0, waddr==raddr_x, rdata_x SHALL capture wdata, not the old register value.
REQ-024 raddr_a==raddr_b SHALL return identical data on both outputs, including under bypass.
REQ-025 Write port SHALL operate independently of FSM state; a write never stalls and is never stalled.
REQ-026 When not accepting, rdata_a/rdata_b SHALL retain their last captured values.

Reset
REQ-027 With rst=1 at a rising edge: all registers to 0, rdata_a=rdata_b=0, rsp_valid=0, FSM to IDLE; req_ready=1 the following cycle.
REQ-028 Reset SHALL take priority over a simultaneous write or request acceptance; a response pending at reset SHALL be dropped.

Structure
REQ-029 Shared package SHALL hold default DW/AW constants and the FSM state encoding (IDLE=0, RESP=1).
REQ-030 One sub-module reg_en SHALL implement a DW-bit register with enable and synchronous active-high reset, used for storage and output data registers.

Verification
REQ-031 Reset then write 0x5A to addr 3, next cycle request a=3,b=0 -> one cycle later rsp_valid=1, rdata_a=0x5A, rdata_b=0x00.
REQ-032 Write 0xFF to addr 0, request a=0 -> rdata_a=0x00.
REQ-033 Addr 5 holds 0x11; same edge write 0x22 to 5 and accept request a=5,b=5 -> rdata_a=rdata_b=0x22.
REQ-034 Response pending, rsp_ready=0 for 4 cycles while writing 0x77 to requested address -> req_ready=0, outputs unchanged, then rsp_ready=1 releases the original data.
REQ-035 req_valid and rsp_ready held 1 with addresses 1,2,3 on consecutive cycles -> three consecutive responses, one per cycle, correct data.
REQ-036 Assert rst while rsp_valid=1 -> next cycle rsp_valid=0, rdata=0, all registers read 0.
